// File: rtl/response_checker.sv
// -----------------------------------------------------------------------------
// response_checker
//
// Sink-side scoreboard for stimulus benches. The stimulus driver pushes the
// expected DUT responses, each with a per-bit care mask, into an internal
// FIFO ahead of the DUT's latency. During a run, every valid DUT sample pops
// one expectation and is compared only on the bits the mask marks as cared
// for. The block keeps a mismatch count, the index of the first failure,
// sticky overflow/underflow flags and a pass/done status. A run therefore
// checks itself instead of being read by eye from a waveform dump.
//
// Ports:
//   clk             rising-edge clock
//   rst_n           synchronous active-low reset
//   start           one-cycle pulse; arms a run from IDLE or DONE
//   num_vec         vectors to check this run (0 = unbounded until stop);
//                   sampled on start
//   stop            one-cycle pulse; ends RUN at the end of this cycle
//   exp_valid       expectation push request
//   exp_ready       FIFO not full (registered)
//   exp_data        expected response
//   exp_care        per-bit care mask, 1 = compared
//   act_valid       DUT sample valid; always accepted
//   act_data        DUT response sample
//   busy            state == RUN
//   done            state == DONE
//   pass            done with no mismatch, overflow or underflow
//   err_count       mismatches this run, saturating
//   vec_count       samples checked this run, saturating
//   first_err_idx   vec_count value at the first mismatch
//   first_err_valid first_err_idx holds data
//   ovf             sticky: push attempted while full
//   udf             sticky: sample arrived while FIFO empty
//   level           FIFO occupancy
// -----------------------------------------------------------------------------
module response_checker #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 8,
   parameter int CNT_W = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic [CNT_W-1:0]         num_vec,
   input  logic                     stop,
   input  logic                     exp_valid,
   output logic                     exp_ready,
   input  logic [WIDTH-1:0]         exp_data,
   input  logic [WIDTH-1:0]         exp_care,
   input  logic                     act_valid,
   input  logic [WIDTH-1:0]         act_data,
   output logic                     busy,
   output logic                     done,
   output logic                     pass,
   output logic [CNT_W-1:0]         err_count,
   output logic [CNT_W-1:0]         vec_count,
   output logic [CNT_W-1:0]         first_err_idx,
   output logic                     first_err_valid,
   output logic                     ovf,
   output logic                     udf,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } state_t;

   // One FIFO slot: the expected value and the mask of bits that matter.
   typedef struct packed {
      logic [WIDTH-1:0] data;
      logic [WIDTH-1:0] care;
   } entry_t;

   state_t           state;
   state_t           state_nxt;

   entry_t           mem [DEPTH];
   entry_t           head;
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [LW-1:0]    level_nxt;

   logic [CNT_W-1:0] num_vec_q;
   logic [CNT_W-1:0] vec_inc;

   logic             empty;
   logic             push;
   logic             push_refused;
   logic             check;
   logic             pop;
   logic             bit_mismatch;
   logic             mismatch;
   logic             terminal;
   logic             run_entry;

   // --------------------------------------------------------------------------
   // Event decode
   // --------------------------------------------------------------------------
   assign empty        = (level == '0);
   // exp_ready is registered from the occupancy. A pop in the same cycle does
   // not open a slot for the push until the following cycle.
   assign push         = exp_valid && exp_ready;
   assign push_refused = exp_valid && !exp_ready;
   assign check        = (state == ST_RUN) && act_valid;
   assign pop          = check && !empty;
   assign head         = mem[rd_ptr];
   assign bit_mismatch = |((act_data ^ head.data) & head.care);
   // An empty FIFO has nothing to compare against. The sample counts as a
   // mismatch, and a same-cycle push is never forwarded to it.
   assign mismatch     = check && (empty || bit_mismatch);
   // The terminal test uses the raw, unsaturated increment. num_vec fits in
   // CNT_W, so the all-ones target is still reachable.
   assign vec_inc      = vec_count + CNT_W'(1);
   assign terminal     = check && (num_vec_q != '0) && (vec_inc == num_vec_q);
   assign run_entry    = (state != ST_RUN) && start;

   // --------------------------------------------------------------------------
   // FSM
   // --------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      // NOTE: every clocked register uses non-blocking assignment. All flops
      // then sample the values from before the edge, whatever order the
      // statements are written in.
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      // NOTE: next-state defaults to the current state before the case.
      // Because every path assigns a value, no latch is inferred.
      state_nxt = state;
      unique case (state)
         ST_IDLE: begin
            if (start) begin
               state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            // When a terminal check and stop arrive together, the FSM makes
            // a single move to DONE.
            if (terminal || stop) begin
               state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            // start beats a simultaneous stop, which means nothing here.
            if (start) begin
               state_nxt = ST_RUN;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign busy = (state == ST_RUN);
   assign done = (state == ST_DONE);
   assign pass = done && (err_count == '0) && !ovf && !udf;

   // --------------------------------------------------------------------------
   // Expectation FIFO
   // --------------------------------------------------------------------------
   // NOTE: the storage array has no reset. Validity is tracked only by
   // pointers and level, so clearing the data would cost a reset net on
   // every bit for nothing.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= '{data: exp_data, care: exp_care};
      end
   end

   always_comb begin
      level_nxt = level;
      unique case ({push, pop})
         2'b10:   level_nxt = level + LW'(1);
         2'b01:   level_nxt = level - LW'(1);
         default: level_nxt = level;
      endcase
   end

   // DEPTH is a power of two, so the pointers wrap naturally at AW bits.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         level     <= '0;
         exp_ready <= 1'b1;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         level     <= level_nxt;
         exp_ready <= (level_nxt != LW'(DEPTH));
      end
   end

   // --------------------------------------------------------------------------
   // Run statistics
   // --------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         num_vec_q       <= '0;
         vec_count       <= '0;
         err_count       <= '0;
         first_err_idx   <= '0;
         first_err_valid <= 1'b0;
         ovf             <= 1'b0;
         udf             <= 1'b0;
      end else if (run_entry) begin
         // A new run clears the statistics but keeps any queued
         // expectations. A refused push in the arming cycle still counts
         // against the new run.
         num_vec_q       <= num_vec;
         vec_count       <= '0;
         err_count       <= '0;
         first_err_idx   <= '0;
         first_err_valid <= 1'b0;
         ovf             <= push_refused;
         udf             <= 1'b0;
      end else begin
         if (push_refused) begin
            ovf <= 1'b1;
         end
         if (check) begin
            if (vec_count != '1) begin
               vec_count <= vec_inc;
            end
            if (empty) begin
               udf <= 1'b1;
            end
         end
         if (mismatch) begin
            if (err_count != '1) begin
               err_count <= err_count + CNT_W'(1);
            end
            if (!first_err_valid) begin
               first_err_idx   <= vec_count;
               first_err_valid <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_response_checker.sv
// -----------------------------------------------------------------------------
// tb_response_checker
//
// Directed bench for response_checker with the default parameters
// (WIDTH=1, DEPTH=8, CNT_W=16). Inputs are driven 1 time unit after each
// rising edge. Outputs are sampled at that same point, so they show the
// result of the edge just taken.
// -----------------------------------------------------------------------------
module tb_response_checker;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [15:0] num_vec;
   logic        stop;
   logic        exp_valid;
   logic        exp_ready;
   logic [0:0]  exp_data;
   logic [0:0]  exp_care;
   logic        act_valid;
   logic [0:0]  act_data;
   logic        busy;
   logic        done;
   logic        pass;
   logic [15:0] err_count;
   logic [15:0] vec_count;
   logic [15:0] first_err_idx;
   logic        first_err_valid;
   logic        ovf;
   logic        udf;
   logic [3:0]  level;

   int vecs;
   int misses;

   response_checker #(
      .WIDTH (1),
      .DEPTH (8),
      .CNT_W (16)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .start           (start),
      .num_vec         (num_vec),
      .stop            (stop),
      .exp_valid       (exp_valid),
      .exp_ready       (exp_ready),
      .exp_data        (exp_data),
      .exp_care        (exp_care),
      .act_valid       (act_valid),
      .act_data        (act_data),
      .busy            (busy),
      .done            (done),
      .pass            (pass),
      .err_count       (err_count),
      .vec_count       (vec_count),
      .first_err_idx   (first_err_idx),
      .first_err_valid (first_err_valid),
      .ovf             (ovf),
      .udf             (udf),
      .level           (level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Watchdog: every scenario runs a fixed number of cycles, so reaching
   // this point means the bench itself has stalled.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time exceeded, got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic d, input logic c);
      exp_valid = 1'b1;
      exp_data  = d;
      exp_care  = c;
      step();
      exp_valid = 1'b0;
   endtask

   task automatic act(input logic d);
      act_valid = 1'b1;
      act_data  = d;
      step();
      act_valid = 1'b0;
   endtask

   task automatic arm(input logic [15:0] n);
      start   = 1'b1;
      num_vec = n;
      step();
      start   = 1'b0;
   endtask

   task automatic pulse_stop();
      stop = 1'b1;
      step();
      stop = 1'b0;
   endtask

   // ---------------------------------------------------------------------------
   task automatic test_reset();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      vecs++; if (busy !== 1'b0) begin misses++; $display("FAIL reset_busy: got %b expected 0", busy); end
      vecs++; if (done !== 1'b0) begin misses++; $display("FAIL reset_done: got %b expected 0", done); end
      vecs++; if (pass !== 1'b0) begin misses++; $display("FAIL reset_pass: got %b expected 0", pass); end
      vecs++; if (exp_ready !== 1'b1) begin misses++; $display("FAIL reset_exp_ready: got %b expected 1", exp_ready); end
      vecs++; if (level !== 4'd0) begin misses++; $display("FAIL reset_level: got %0d expected 0", level); end
      vecs++; if (err_count !== 16'd0) begin misses++; $display("FAIL reset_err_count: got %0d expected 0", err_count); end
      vecs++; if (vec_count !== 16'd0) begin misses++; $display("FAIL reset_vec_count: got %0d expected 0", vec_count); end
      vecs++; if (first_err_valid !== 1'b0) begin misses++; $display("FAIL reset_first_err_valid: got %b expected 0", first_err_valid); end
      vecs++; if ({ovf, udf} !== 2'b00) begin misses++; $display("FAIL reset_ovf_udf: got %b expected 00", {ovf, udf}); end
   endtask

   // ---------------------------------------------------------------------------
   task automatic test_all_match();
      push(1'b0, 1'b1);
      push(1'b0, 1'b1);
      push(1'b0, 1'b1);
      push(1'b1, 1'b1);
      vecs++; if (level !== 4'd4) begin misses++; $display("FAIL match_level_loaded: got %0d expected 4", level); end
      arm(16'd4);
      vecs++; if (busy !== 1'b1) begin misses++; $display("FAIL match_busy: got %b expected 1", busy); end
      act(1'b0);
      act(1'b0);
      act(1'b0);
      vecs++; if (done !== 1'b0 || vec_count !== 16'd3) begin misses++; $display("FAIL match_early_done: got done=%b vec=%0d expected done=0 vec=3", done, vec_count); end
      act(1'b1);
      vecs++; if (done !== 1'b1) begin misses++; $display("FAIL match_done: got %b expected 1", done); end
      vecs++; if (vec_count !== 16'd4) begin misses++; $display("FAIL match_vec_count: got %0d expected 4", vec_count); end
      vecs++; if (err_count !== 16'd0) begin misses++; $display("FAIL match_err_count: got %0d expected 0", err_count); end
      vecs++; if (pass !== 1'b1) begin misses++; $display("FAIL match_pass: got %b expected 1", pass); end
      vecs++; if (first_err_valid !== 1'b0) begin misses++; $display("FAIL match_first_err_valid: got %b expected 0", first_err_valid); end
      vecs++; if (level !== 4'd0) begin misses++; $display("FAIL match_level_drained: got %0d expected 0", level); end
   endtask

   // ---------------------------------------------------------------------------
   task automatic test_mismatch_dont_care();
      push(1'b1, 1'b1);
      push(1'b0, 1'b0);
      push(1'b1, 1'b1);
      // A sample outside RUN must neither pop nor count.
      act(1'b0);
      vecs++; if (level !== 4'd3 || vec_count !== 16'd4) begin misses++; $display("FAIL idle_act_ignored: got level=%0d vec=%0d expected level=3 vec=4", level, vec_count); end
      arm(16'd3);
      vecs++; if (vec_count !== 16'd0 || pass !== 1'b0) begin misses++; $display("FAIL rearm_clear: got vec=%0d pass=%b expected vec=0 pass=0", vec_count, pass); end
      act(1'b0);
      vecs++; if (err_count !== 16'd1 || first_err_valid !== 1'b1) begin misses++; $display("FAIL mm_first: got err=%0d fev=%b expected err=1 fev=1", err_count, first_err_valid); end
      act(1'b1);
      vecs++; if (err_count !== 16'd1) begin misses++; $display("FAIL mm_dont_care: got err=%0d expected 1", err_count); end
      act(1'b1);
      vecs++; if (done !== 1'b1 || vec_count !== 16'd3) begin misses++; $display("FAIL mm_done: got done=%b vec=%0d expected done=1 vec=3", done, vec_count); end
      vecs++; if (err_count !== 16'd1) begin misses++; $display("FAIL mm_err_count: got %0d expected 1", err_count); end
      vecs++; if (first_err_idx !== 16'd0) begin misses++; $display("FAIL mm_first_err_idx: got %0d expected 0", first_err_idx); end
      vecs++; if (pass !== 1'b0) begin misses++; $display("FAIL mm_pass: got %b expected 0", pass); end
   endtask

   // ---------------------------------------------------------------------------
   task automatic test_overflow_wrap();
      logic [7:0] tail;
      arm(16'd0);
      for (int i = 0; i < 8; i++) begin
         push(logic'(i % 2), 1'b1);
      end
      vecs++; if (level !== 4'd8) begin misses++; $display("FAIL ovf_level_full: got %0d expected 8", level); end
      vecs++; if (exp_ready !== 1'b0) begin misses++; $display("FAIL ovf_ready_low: got %b expected 0", exp_ready); end
      // Ninth push while full: the data is dropped and the flag sets.
      push(1'b1, 1'b1);
      vecs++; if (ovf !== 1'b1 || level !== 4'd8) begin misses++; $display("FAIL ovf_ninth: got ovf=%b level=%0d expected ovf=1 level=8", ovf, level); end
      // Full FIFO with a same-cycle pop: the push is still refused.
      exp_valid = 1'b1; exp_data = 1'b0; exp_care = 1'b1;
      act_valid = 1'b1; act_data = 1'b0;
      step();
      exp_valid = 1'b0; act_valid = 1'b0;
      vecs++; if (level !== 4'd7 || exp_ready !== 1'b1) begin misses++; $display("FAIL ovf_full_pop_push: got level=%0d ready=%b expected level=7 ready=1", level, exp_ready); end
      // Non-full push together with a pop: level unchanged.
      exp_valid = 1'b1; exp_data = 1'b1; exp_care = 1'b1;
      act_valid = 1'b1; act_data = 1'b1;
      step();
      exp_valid = 1'b0; act_valid = 1'b0;
      vecs++; if (level !== 4'd7) begin misses++; $display("FAIL push_pop_level: got %0d expected 7", level); end
      act(1'b0);
      push(1'b0, 1'b1);
      push(1'b1, 1'b1);
      vecs++; if (level !== 4'd8 || exp_ready !== 1'b0) begin misses++; $display("FAIL wrap_refill: got level=%0d ready=%b expected level=8 ready=0", level, exp_ready); end
      // Queue is now 1,0,1,0,1,1,0,1 (head first), spanning the pointer wrap.
      tail = 8'b1011_0101;
      for (int i = 0; i < 8; i++) begin
         act(tail[i]);
      end
      pulse_stop();
      vecs++; if (err_count !== 16'd0) begin misses++; $display("FAIL wrap_err_count: got %0d expected 0", err_count); end
      vecs++; if (vec_count !== 16'd11) begin misses++; $display("FAIL wrap_vec_count: got %0d expected 11", vec_count); end
      vecs++; if (done !== 1'b1 || ovf !== 1'b1 || udf !== 1'b0 || pass !== 1'b0) begin misses++; $display("FAIL wrap_status: got done=%b ovf=%b udf=%b pass=%b expected 1 1 0 0", done, ovf, udf, pass); end
      vecs++; if (level !== 4'd0) begin misses++; $display("FAIL wrap_level: got %0d expected 0", level); end
   endtask

   // ---------------------------------------------------------------------------
   task automatic test_underflow();
      arm(16'd0);
      vecs++; if (ovf !== 1'b0) begin misses++; $display("FAIL udf_ovf_cleared: got %b expected 0", ovf); end
      act(1'b0);
      vecs++; if (udf !== 1'b1) begin misses++; $display("FAIL udf_flag: got %b expected 1", udf); end
      vecs++; if (err_count !== 16'd1 || vec_count !== 16'd1) begin misses++; $display("FAIL udf_counts: got err=%0d vec=%0d expected err=1 vec=1", err_count, vec_count); end
      vecs++; if (level !== 4'd0) begin misses++; $display("FAIL udf_level: got %0d expected 0", level); end
      vecs++; if (first_err_valid !== 1'b1 || first_err_idx !== 16'd0) begin misses++; $display("FAIL udf_first_err: got fev=%b idx=%0d expected fev=1 idx=0", first_err_valid, first_err_idx); end
      pulse_stop();
      vecs++; if (done !== 1'b1 || pass !== 1'b0) begin misses++; $display("FAIL udf_done: got done=%b pass=%b expected done=1 pass=0", done, pass); end
   endtask

   // ---------------------------------------------------------------------------
   task automatic test_unbounded_stop();
      arm(16'd0);
      // Pipelined: push d[i] while checking d[i-1]; d[i] = (i % 3 == 0).
      push(1'b1, 1'b1);
      for (int i = 1; i < 20; i++) begin
         exp_valid = 1'b1; exp_data = logic'(i % 3 == 0); exp_care = 1'b1;
         act_valid = 1'b1; act_data = logic'((i - 1) % 3 == 0);
         step();
      end
      exp_valid = 1'b0;
      act_valid = 1'b1; act_data = 1'b0;   // d[19]: 19 % 3 != 0
      step();
      act_valid = 1'b0;
      // Two leftovers for the next run.
      push(1'b1, 1'b1);
      push(1'b0, 1'b1);
      vecs++; if (busy !== 1'b1) begin misses++; $display("FAIL unb_still_busy: got %b expected 1", busy); end
      pulse_stop();
      vecs++; if (done !== 1'b1 || vec_count !== 16'd20) begin misses++; $display("FAIL unb_stop: got done=%b vec=%0d expected done=1 vec=20", done, vec_count); end
      vecs++; if (err_count !== 16'd0 || pass !== 1'b1) begin misses++; $display("FAIL unb_clean: got err=%0d pass=%b expected err=0 pass=1", err_count, pass); end
      vecs++; if (level !== 4'd2) begin misses++; $display("FAIL unb_leftover: got %0d expected 2", level); end
      arm(16'd2);
      vecs++; if (vec_count !== 16'd0 || level !== 4'd2) begin misses++; $display("FAIL rerun_clear: got vec=%0d level=%0d expected vec=0 level=2", vec_count, level); end
      // start while in RUN is ignored: counters keep going.
      start = 1'b1; num_vec = 16'd9;
      act(1'b1);
      start = 1'b0;
      vecs++; if (vec_count !== 16'd1 || busy !== 1'b1) begin misses++; $display("FAIL run_start_ignored: got vec=%0d busy=%b expected vec=1 busy=1", vec_count, busy); end
      act(1'b0);
      vecs++; if (done !== 1'b1 || err_count !== 16'd0 || pass !== 1'b1) begin misses++; $display("FAIL rerun_done: got done=%b err=%0d pass=%b expected 1 0 1", done, err_count, pass); end
   endtask

   // ---------------------------------------------------------------------------
   task automatic test_mid_run_reset();
      arm(16'd0);
      act(1'b0);
      act(1'b0);
      for (int i = 0; i < 5; i++) begin
         push(1'b0, 1'b1);
      end
      vecs++; if (level !== 4'd5 || err_count !== 16'd2) begin misses++; $display("FAIL mrr_setup: got level=%0d err=%0d expected level=5 err=2", level, err_count); end
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      vecs++; if (busy !== 1'b0 || done !== 1'b0) begin misses++; $display("FAIL mrr_state: got busy=%b done=%b expected 0 0", busy, done); end
      vecs++; if (level !== 4'd0 || exp_ready !== 1'b1) begin misses++; $display("FAIL mrr_fifo: got level=%0d ready=%b expected level=0 ready=1", level, exp_ready); end
      vecs++; if (err_count !== 16'd0 || vec_count !== 16'd0) begin misses++; $display("FAIL mrr_counts: got err=%0d vec=%0d expected 0 0", err_count, vec_count); end
      vecs++; if ({ovf, udf} !== 2'b00) begin misses++; $display("FAIL mrr_flags: got %b expected 00", {ovf, udf}); end
      // Stale entries must be gone: a fresh single vector compares cleanly.
      push(1'b1, 1'b1);
      arm(16'd1);
      act(1'b1);
      vecs++; if (done !== 1'b1 || pass !== 1'b1 || err_count !== 16'd0) begin misses++; $display("FAIL mrr_fresh_run: got done=%b pass=%b err=%0d expected 1 1 0", done, pass, err_count); end
   endtask

   initial begin
      vecs      = 0;
      misses    = 0;
      rst_n     = 1'b0;
      start     = 1'b0;
      num_vec   = '0;
      stop      = 1'b0;
      exp_valid = 1'b0;
      exp_data  = '0;
      exp_care  = '0;
      act_valid = 1'b0;
      act_data  = '0;
      #1;
      test_reset();
      test_all_match();
      test_mismatch_dont_care();
      test_overflow_wrap();
      test_underflow();
      test_unbounded_stop();
      test_mid_run_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, misses);
      $finish;
   end

endmodule
